tft_timing_gen: RTL and testbench

Video timing generator for the 480x272 TFT-LCD panel: divides the system clock into the panel pixel clock and drives TCLK, Hsync, Vsync and DE plus active-area pixel coordinates and a linear frame-buffer address. It is the source side of the timing that the LCD controller, BRAM controller and tracker consume. It replaces the separate clock-divider, horizontal and vertical generators with one frame-synchronous block.

---
 rtl/tft_timing_gen_pkg.sv | 29 ++
 rtl/tft_pix_div.sv | 37 +++
 rtl/tft_timing_gen.sv | 123 ++++++++++++
 tb/tb_tft_timing_gen.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tft_timing_gen_pkg.sv
// Shared constants and types for the TFT panel timing generator.
// Defaults match the 480x272 TFT-LCD panel.
package tft_timing_gen_pkg;

    localparam int unsigned CLK_DIV_DEF = 6;

    localparam int unsigned H_SYNC_DEF = 41;
    localparam int unsigned H_BP_DEF   = 2;
    localparam int unsigned H_ACT_DEF  = 480;
    localparam int unsigned H_FP_DEF   = 2;
    localparam int unsigned H_TOTAL_DEF =
        H_SYNC_DEF + H_BP_DEF + H_ACT_DEF + H_FP_DEF;

    localparam int unsigned V_SYNC_DEF = 10;
    localparam int unsigned V_BP_DEF   = 2;
    localparam int unsigned V_ACT_DEF  = 272;
    localparam int unsigned V_FP_DEF   = 2;
    localparam int unsigned V_TOTAL_DEF =
        V_SYNC_DEF + V_BP_DEF + V_ACT_DEF + V_FP_DEF;

    localparam int unsigned CNT_W  = 10;
    localparam int unsigned ADDR_W = 17;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

endpackage

// File: rtl/tft_pix_div.sv
// Pixel clock divider: free-running div_cnt, 50% duty TCLK and
// a pix_en strobe on the CLK edge where TCLK falls.
module tft_pix_div #(
    parameter int unsigned CLK_DIV = 6
) (
    input  logic CLK,
    input  logic nRESET,
    output logic TCLK,
    output logic pix_en
);

    localparam int unsigned W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);
    localparam logic [W-1:0] HALF = W'(CLK_DIV / 2);

    logic [W-1:0] div_q;
    logic [W-1:0] div_d;
    logic         tclk_q;

    always_comb begin
        div_d = (div_q == LAST) ? '0 : div_q + W'(1);
    end

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            div_q  <= '0;
            tclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tclk_q <= (div_d >= HALF);
        end
    end

    assign pix_en = (div_q == LAST);
    assign TCLK   = tclk_q;

endmodule

// File: rtl/tft_timing_gen.sv
// Frame-synchronous TFT timing generator: h/v counters, run FSM,
// sync/DE decode and incremental frame-buffer address.
module tft_timing_gen
    import tft_timing_gen_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEF,
    parameter int unsigned H_SYNC  = H_SYNC_DEF,
    parameter int unsigned H_BP    = H_BP_DEF,
    parameter int unsigned H_ACT   = H_ACT_DEF,
    parameter int unsigned H_FP    = H_FP_DEF,
    parameter int unsigned V_SYNC  = V_SYNC_DEF,
    parameter int unsigned V_BP    = V_BP_DEF,
    parameter int unsigned V_ACT   = V_ACT_DEF,
    parameter int unsigned V_FP    = V_FP_DEF
) (
    input  logic              CLK,
    input  logic              nRESET,
    input  logic              EN,
    output logic              TCLK,
    output logic              pix_en,
    output logic              Hsync,
    output logic              Vsync,
    output logic              DE,
    output logic [CNT_W-1:0]  H_COUNT,
    output logic [CNT_W-1:0]  V_COUNT,
    output logic [ADDR_W-1:0] BRAMADDR,
    output logic              frame_start
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_SYNC + H_BP + H_ACT + H_FP - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_SYNC + V_BP + V_ACT + V_FP - 1);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] HA_BEG = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] HA_END = CNT_W'(H_SYNC + H_BP + H_ACT);
    localparam logic [CNT_W-1:0] VA_BEG = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] VA_END = CNT_W'(V_SYNC + V_BP + V_ACT);

    state_e              state_q;
    logic [CNT_W-1:0]    h_q, v_q;
    logic [CNT_W-1:0]    h_d, v_d;
    logic                hs_q, vs_q, de_q, fs_q;
    logic [CNT_W-1:0]    hc_q, vc_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                eof, start, stop, run_d, act_d;

    tft_pix_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .CLK    (CLK),
        .nRESET (nRESET),
        .TCLK   (TCLK),
        .pix_en (pix_en)
    );

    // EN only matters at a frame boundary; frames are never cut short.
    always_comb begin
        eof   = (h_q == H_LAST) && (v_q == V_LAST);
        start = pix_en && EN && ((state_q == IDLE) || eof);
        stop  = pix_en && !EN && (state_q == RUN) && eof;
        run_d = start || ((state_q == RUN) && !stop);
        h_d   = h_q;
        v_d   = v_q;
        if (start) begin
            h_d = '0;
            v_d = '0;
        end else if (stop) begin
            h_d = H_LAST;
            v_d = V_LAST;
        end else if (pix_en && (state_q == RUN)) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = v_q + CNT_W'(1);
            end else begin
                h_d = h_q + CNT_W'(1);
            end
        end
        act_d = run_d && (h_d >= HA_BEG) && (h_d < HA_END)
                      && (v_d >= VA_BEG) && (v_d < VA_END);
    end

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            state_q <= IDLE;
            h_q     <= H_LAST;
            v_q     <= V_LAST;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            de_q    <= 1'b0;
            hc_q    <= '0;
            vc_q    <= '0;
            addr_q  <= '0;
            fs_q    <= 1'b0;
        end else begin
            fs_q <= start;
            if (pix_en) begin
                state_q <= run_d ? RUN : IDLE;
                h_q     <= h_d;
                v_q     <= v_d;
                hs_q    <= !(run_d && (h_d < HS_END));
                vs_q    <= !(run_d && (v_d < VS_END));
                de_q    <= act_d;
                hc_q    <= act_d ? h_d - HA_BEG : '0;
                vc_q    <= act_d ? v_d - VA_BEG : '0;
                // Address advances after each active pixel, holds otherwise.
                if (!run_d || start) begin
                    addr_q <= '0;
                end else if (de_q) begin
                    addr_q <= addr_q + ADDR_W'(1);
                end
            end
        end
    end

    assign Hsync       = hs_q;
    assign Vsync       = vs_q;
    assign DE          = de_q;
    assign H_COUNT     = hc_q;
    assign V_COUNT     = vc_q;
    assign BRAMADDR    = addr_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_tft_timing_gen.sv
// Directed bench: default panel timing start-up plus a small-parameter
// instance for full-frame, EN-drop and restart behaviour.
module tb_tft_timing_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_b, en_s;

    logic        b_tclk, b_pen, b_hs, b_vs, b_de, b_fs;
    logic [9:0]  b_hc, b_vc;
    logic [16:0] b_addr;

    logic        s_tclk, s_pen, s_hs, s_vs, s_de, s_fs;
    logic [9:0]  s_hc, s_vc;
    logic [16:0] s_addr;

    int n_tot = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tft_timing_gen u_big (
        .CLK         (clk),
        .nRESET      (rst_n),
        .EN          (en_b),
        .TCLK        (b_tclk),
        .pix_en      (b_pen),
        .Hsync       (b_hs),
        .Vsync       (b_vs),
        .DE          (b_de),
        .H_COUNT     (b_hc),
        .V_COUNT     (b_vc),
        .BRAMADDR    (b_addr),
        .frame_start (b_fs)
    );

    tft_timing_gen #(
        .CLK_DIV (2),
        .H_SYNC  (1), .H_BP (1), .H_ACT (4), .H_FP (1),
        .V_SYNC  (1), .V_BP (1), .V_ACT (3), .V_FP (1)
    ) u_sml (
        .CLK         (clk),
        .nRESET      (rst_n),
        .EN          (en_s),
        .TCLK        (s_tclk),
        .pix_en      (s_pen),
        .Hsync       (s_hs),
        .Vsync       (s_vs),
        .DE          (s_de),
        .H_COUNT     (s_hc),
        .V_COUNT     (s_vc),
        .BRAMADDR    (s_addr),
        .frame_start (s_fs)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_big_reset(input string pfx);
        check({pfx, "_tclk"}, 32'(b_tclk), 0);
        check({pfx, "_pen"},  32'(b_pen),  0);
        check({pfx, "_hs"},   32'(b_hs),   1);
        check({pfx, "_vs"},   32'(b_vs),   1);
        check({pfx, "_de"},   32'(b_de),   0);
        check({pfx, "_hc"},   32'(b_hc),   0);
        check({pfx, "_vc"},   32'(b_vc),   0);
        check({pfx, "_addr"}, 32'(b_addr), 0);
        check({pfx, "_fs"},   32'(b_fs),   0);
    endtask

    initial begin
        int k, p, ph, h, v;
        int first_de, hs_low, vs_low, vs_off, bad_edge, tclk_hi;
        int de_bad, idx, last_addr, fs_extra, de_cnt, idle_bad, rises;
        logic [6:0]  pat;
        logic [63:0] prev_o, cur_o;
        logic        prev_tclk, prev_vs;

        rst_n = 1'b0;
        en_b  = 1'b0;
        en_s  = 1'b0;
        repeat (3) tick();
        chk_big_reset("rst");

        // Release with EN high: first pixel (0,0) after CLK_DIV edges.
        rst_n = 1'b1;
        en_b  = 1'b1;
        en_s  = 1'b1;
        k = 0;
        while (k < 20 && !b_fs) begin
            tick();
            k++;
        end
        check("first_fs_lat", 32'(k), 6);
        check("first_hs", 32'(b_hs), 0);
        check("first_vs", 32'(b_vs), 0);
        check("first_de", 32'(b_de), 0);

        first_de = -1;
        hs_low   = 0;
        vs_low   = 0;
        vs_off   = 0;
        bad_edge = 0;
        tclk_hi  = 0;
        prev_o   = {b_hs, b_vs, b_de, b_hc, b_vc, b_addr};
        prev_tclk = b_tclk;
        prev_vs   = b_vs;
        for (int c = 0; c < 6 * 6346; c++) begin
            if (c > 0) tick();
            p  = c / 6;
            ph = c % 6;
            cur_o = {b_hs, b_vs, b_de, b_hc, b_vc, b_addr};
            if (cur_o != prev_o && !(prev_tclk && !b_tclk))
                bad_edge++;
            prev_o    = cur_o;
            prev_tclk = b_tclk;
            if (p == 0) tclk_hi += int'(b_tclk);
            if (c == 0) check("tclk_at_pix", 32'(b_tclk), 0);
            if (ph == 0) begin
                if (p < 525 && !b_hs) hs_low++;
                if (!b_vs) vs_low++;
                if (b_vs != prev_vs && (p % 525) != 0) vs_off++;
                prev_vs = b_vs;
                if (b_de && first_de < 0) begin
                    first_de = p;
                    check("de0_hc",   32'(b_hc),   0);
                    check("de0_vc",   32'(b_vc),   0);
                    check("de0_addr", 32'(b_addr), 0);
                end
                if (first_de >= 0 && p == first_de + 1) begin
                    check("de1_hc",   32'(b_hc),   1);
                    check("de1_addr", 32'(b_addr), 1);
                end
            end
        end
        check("tclk_duty_hi", 32'(tclk_hi), 3);
        check("hs_low_pix", 32'(hs_low), 41);
        check("vs_low_pix", 32'(vs_low), 5250);
        check("vs_edge_h0", 32'(vs_off), 0);
        check("first_de_pix", 32'(first_de), 12 * 525 + 43);
        check("edge_on_tfall", 32'(bad_edge), 0);

        // Small instance: one full frame of 7x6 pixels.
        k = 0;
        while (k < 300 && !s_fs) begin
            tick();
            k++;
        end
        check("s_fs_seen", 32'(s_fs), 1);
        de_bad    = 0;
        idx       = 0;
        last_addr = -1;
        fs_extra  = 0;
        pat       = '0;
        for (int c = 0; c <= 84; c++) begin
            if (c > 0) tick();
            p = c / 2;
            h = p % 7;
            v = p / 7;
            if (c > 0 && c < 84 && s_fs) fs_extra++;
            if (c < 84 && (c % 2) == 0) begin
                if (s_de !== (h >= 2 && h < 6 && v >= 2 && v < 5))
                    de_bad++;
                if (v == 3) pat[h] = s_de;
                if (s_de) begin
                    if (int'(s_addr) != idx || int'(s_hc) != h - 2
                        || int'(s_vc) != v - 2)
                        de_bad++;
                    last_addr = int'(s_addr);
                    idx++;
                end
            end
        end
        check("s_fs_period", 32'(s_fs), 1);
        check("s_fs_extra", 32'(fs_extra), 0);
        check("s_de_line", 32'(pat), 32'b0111100);
        check("s_de_bad", 32'(de_bad), 0);
        check("s_de_count", 32'(idx), 12);
        check("s_last_addr", 32'(last_addr), 11);

        // Drop EN at the start of a frame: that frame still completes.
        en_s   = 1'b0;
        de_cnt = 0;
        for (int c = 0; c < 84; c++) begin
            if ((c % 2) == 0 && s_de) de_cnt++;
            tick();
        end
        check("s_drop_de", 32'(de_cnt), 12);
        check("s_idle_fs", 32'(s_fs), 0);
        check("s_idle_hs", 32'(s_hs), 1);
        check("s_idle_vs", 32'(s_vs), 1);
        idle_bad  = 0;
        rises     = 0;
        prev_tclk = s_tclk;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (!s_hs || !s_vs || s_de || s_fs || s_addr != 0) idle_bad++;
            if (!prev_tclk && s_tclk) rises++;
            prev_tclk = s_tclk;
        end
        check("s_idle_bad", 32'(idle_bad), 0);
        check("s_idle_tclk", 32'(rises), 20);

        en_s = 1'b1;
        k = 0;
        while (k < 10 && !s_fs) begin
            tick();
            k++;
        end
        check("s_restart_fs", 32'(s_fs), 1);
        check("s_restart_ok", 32'(k >= 1 && k <= 2), 1);
        check("s_restart_hs", 32'(s_hs), 0);
        check("s_restart_addr", 32'(s_addr), 0);

        // Mid-frame reset on the default instance.
        rst_n = 1'b0;
        tick();
        chk_big_reset("mid_rst");
        rst_n = 1'b1;
        k = 0;
        while (k < 20 && !b_fs) begin
            tick();
            k++;
        end
        check("rst_fs_lat", 32'(k), 6);
        check("rst_addr", 32'(b_addr), 0);
        check("rst_hs", 32'(b_hs), 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
